// File: rtl/shift_seq_pkg.sv
// Shared types and sizing helpers for the shift register sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter width must hold both WIDTH-1 and DIV-1.
  function automatic int cnt_width(input int width, input int div);
    int m;
    m = (width > div) ? width : div;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/shift_seq_dp.sv
// Parallel-load, zero-fill left shift register with async active-low clear.
module shift_seq_dp #(
  parameter int WIDTH = 4
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer: accepts a word over valid/ready, then serialises it MSB-first,
// one bit every DIV clocks, with load/shift strobes and busy/done status.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             ser_out,
  output logic             load,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  localparam int CW = cnt_width(WIDTH, DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    div_cnt;
  logic             rdy_q;
  logic [WIDTH-1:0] shreg;
  logic             clr;
  logic             unused_low_bits;

  // Handshake: a word transfers on any edge where in_valid and in_ready are
  // both high; the producer holds in_data stable until that edge, and abort
  // withdraws in_ready in the same cycle.
  assign in_ready  = rdy_q & ~abort;
  assign load      = in_valid & in_ready;
  assign shift_en  = (state == SHIFT) && (div_cnt == '0) && (bit_cnt != '0) && !abort;
  assign clr       = abort && (state != IDLE);
  assign ser_out   = (state == SHIFT) & shreg[WIDTH-1];
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  // Only the MSB leaves the datapath; the rest shifts up inside it.
  assign unused_low_bits = ^shreg[WIDTH-2:0];

  shift_seq_dp #(.WIDTH(WIDTH)) u_dp (
    .c     (c),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (load),
    .shift (shift_en),
    .d     (in_data),
    .q     (shreg)
  );

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      div_cnt <= '0;
      rdy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state   <= SHIFT;
            bit_cnt <= BIT_LAST;
            div_cnt <= DIV_LAST;
            rdy_q   <= 1'b0;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            rdy_q <= 1'b1;
          end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - CW'(1);
          end else if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CW'(1);
            div_cnt <= DIV_LAST;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          rdy_q <= 1'b1;
        end
        default: begin
          state <= IDLE;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: a DIV=1 and a DIV=3 instance checked every cycle
// against a cycle-position reference model, plus vector tables and corner cases.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic         vld;
    logic [W-1:0] dat;
    logic         rdy;
    logic         ld;
    logic         bsy;
    logic         so;
    logic         sh;
    logic         dn;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic c = 1'b0;
  logic rst_n;
  always #5 c = ~c;

  logic [1:0]   vld, abt, rdy, ld, so, sh, bsy, dn;
  logic [W-1:0] dat [2];
  state_t       st0, st1;

  shift_seq_ctrl #(.WIDTH(W), .DIV(1)) u_div1 (
    .c(c), .rst_n(rst_n), .in_valid(vld[0]), .in_data(dat[0]), .in_ready(rdy[0]),
    .abort(abt[0]), .ser_out(so[0]), .load(ld[0]), .shift_en(sh[0]), .busy(bsy[0]),
    .done(dn[0]), .dbg_state(st0)
  );

  shift_seq_ctrl #(.WIDTH(W), .DIV(3)) u_div3 (
    .c(c), .rst_n(rst_n), .in_valid(vld[1]), .in_data(dat[1]), .in_ready(rdy[1]),
    .abort(abt[1]), .ser_out(so[1]), .load(ld[1]), .shift_en(sh[1]), .busy(bsy[1]),
    .done(dn[1]), .dbg_state(st1)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q0 [$];
  logic [W-1:0] exp_q1 [$];

  // Reference model: a word in flight is described by t, the number of
  // cycles since its accept edge (cycle 1 is the first data cycle).
  bit           m_active [2];
  int           m_t      [2];
  bit           m_rdy    [2];
  logic [W-1:0] m_word   [2];
  bit           pend_ld  [2];
  logic [W-1:0] asm_w    [2];

  logic [1:0] s_rdy, s_ld, s_so, s_sh, s_bsy, s_dn;
  state_t     s_st0;
  vec_t       tbl [7];

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic r, input logic l,
                              input logic b, input logic s, input logic e, input logic n);
    vec_t x;
    x.vld = v; x.dat = d; x.rdy = r; x.ld = l; x.bsy = b; x.so = s; x.sh = e; x.dn = n;
    return x;
  endfunction

  task automatic q_push(input int i, input logic [W-1:0] w);
    if (i == 0) exp_q0.push_back(w);
    else exp_q1.push_back(w);
  endtask

  task automatic q_pop(input int i, output logic [W-1:0] w);
    w = 'x;
    if (i == 0 && exp_q0.size() > 0) w = exp_q0.pop_front();
    if (i == 1 && exp_q1.size() > 0) w = exp_q1.pop_front();
  endtask

  task automatic model_reset_all();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0; m_t[i] = 0; m_rdy[i] = 1'b0; pend_ld[i] = 1'b0; asm_w[i] = '0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic check_cycle(input int i);
    int d;
    logic e_rdy, e_ld, e_so, e_sh, e_dn;
    logic [W-1:0] w;
    d = div_of(i);
    e_so = 1'b0;
    if (m_active[i] && m_t[i] <= W * d) e_so = m_word[i][W - 1 - (m_t[i] - 1) / d];
    e_sh = m_active[i] && (m_t[i] < W * d) && (m_t[i] % d == 0) && !abt[i];
    e_dn = m_active[i] && (m_t[i] == W * d + 1);
    e_rdy = !m_active[i] && m_rdy[i] && !abt[i];
    e_ld = vld[i] && e_rdy;
    pend_ld[i] = e_ld;
    chk("in_ready", i, rdy[i], e_rdy);
    chk("load", i, ld[i], e_ld);
    chk("busy", i, bsy[i], m_active[i]);
    chk("ser_out", i, so[i], e_so);
    chk("shift_en", i, sh[i], e_sh);
    chk("done", i, dn[i], e_dn);
    if (m_active[i] && m_t[i] <= W * d && ((m_t[i] - 1) % d == 0))
      asm_w[i] = {asm_w[i][W-2:0], so[i]};
    if (e_dn) begin
      q_pop(i, w);
      chk("serial_word", i, asm_w[i], w);
    end
  endtask

  task automatic step_model(input int i);
    int d;
    logic [W-1:0] w;
    d = div_of(i);
    if (!rst_n) begin
      m_active[i] = 1'b0; m_rdy[i] = 1'b0;
    end else if (pend_ld[i]) begin
      m_active[i] = 1'b1; m_t[i] = 1; m_word[i] = dat[i]; m_rdy[i] = 1'b0; asm_w[i] = '0;
      q_push(i, dat[i]);
    end else if (m_active[i]) begin
      if (m_t[i] == W * d + 1) begin
        m_active[i] = 1'b0; m_rdy[i] = 1'b1;
      end else if (abt[i]) begin
        q_pop(i, w);
        m_active[i] = 1'b0; m_rdy[i] = 1'b1;
      end else begin
        m_t[i]++;
      end
    end else begin
      m_rdy[i] = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input int row);
    @(negedge c);
    s_rdy = rdy; s_ld = ld; s_so = so; s_sh = sh; s_bsy = bsy; s_dn = dn; s_st0 = st0;
    check_cycle(0);
    check_cycle(1);
    if (row >= 0) begin
      chk("tbl_ready", row, rdy[0], tbl[row].rdy);
      chk("tbl_load", row, ld[0], tbl[row].ld);
      chk("tbl_busy", row, bsy[0], tbl[row].bsy);
      chk("tbl_ser", row, so[0], tbl[row].so);
      chk("tbl_shift", row, sh[0], tbl[row].sh);
      chk("tbl_done", row, dn[0], tbl[row].dn);
    end
    @(posedge c);
    step_model(0);
    step_model(1);
    #1;
  endtask

  task automatic run_table();
    for (int k = 0; k < 7; k++) begin
      vld[0] = tbl[k].vld;
      dat[0] = tbl[k].dat;
      abt[0] = 1'b0;
      cycle(k);
    end
    vld[0] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at, nsh, first, second, nd;
    int shq [$];
    logic [11:0] ser12;
    logic [9:0]  stream;

    // 1011 with DIV=1, starting from IDLE with in_ready high
    tbl[0] = mk(1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[2] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[3] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[4] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[5] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[6] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b0; vld = 2'b11; abt = 2'b00; dat[0] = 4'hA; dat[1] = 4'h5;
    model_reset_all();

    // reset held 3 cycles with in_valid high
    repeat (3) cycle(-1);
    chk("rst_ready", 0, s_rdy, 2'b00);
    chk("rst_load", 0, s_ld, 2'b00);
    chk("rst_busy", 0, s_bsy, 2'b00);
    rst_n = 1'b1;
    cycle(-1);
    vld = 2'b00;
    chk("ready_after_rst", 0, rdy, 2'b11);

    run_table();

    // DIV=3, 0110: bits held 3 cycles, done on cycle 13
    vld[1] = 1'b1; dat[1] = 4'b0110;
    cycle(-1);
    chk("div3_load", 1, s_ld[1], 1'b1);
    vld[1] = 1'b0;
    done_at = 0; nsh = 0; ser12 = '0;
    for (int k = 1; k <= 20 && done_at == 0; k++) begin
      cycle(-1);
      if (k <= 12) ser12 = {ser12[10:0], s_so[1]};
      if (s_sh[1]) begin nsh++; shq.push_back(k); end
      if (s_dn[1]) done_at = k;
    end
    chk("div3_done_cycle", 1, done_at, 13);
    chk("div3_shift_count", 1, nsh, 3);
    chk("div3_stream", 1, ser12, 12'b000111111000);
    for (int j = 0; j < 3; j++) chk("div3_shift_pos", j, (shq.size() > j) ? shq[j] : -1, 3 * (j + 1));
    cycle(-1);

    // back-to-back with in_valid held
    vld[0] = 1'b1; dat[0] = 4'b0011; first = -1; second = -1; stream = '0;
    for (int n = 0; n < 12; n++) begin
      cycle(-1);
      if (s_ld[0]) begin
        if (first < 0) begin first = n; dat[0] = 4'b1100; end
        else if (second < 0) begin second = n; vld[0] = 1'b0; end
      end
      if (first >= 0 && n > first && n <= first + 10) stream = {stream[8:0], s_so[0]};
    end
    vld[0] = 1'b0;
    chk("b2b_first", 0, first, 0);
    chk("b2b_gap", 0, second - first, 6);
    chk("b2b_stream", 0, stream, 10'b0011001100);
    repeat (4) cycle(-1);

    // abort during the 2nd bit of 1111
    vld[0] = 1'b1; dat[0] = 4'b1111;
    cycle(-1);
    vld[0] = 1'b0;
    cycle(-1);
    abt[0] = 1'b1;
    cycle(-1);
    abt[0] = 1'b0;
    cycle(-1);
    chk("abort_ser", 0, s_so[0], 1'b0);
    chk("abort_busy", 0, s_bsy[0], 1'b0);
    chk("abort_ready", 0, s_rdy[0], 1'b1);
    chk("abort_state", 0, s_st0, IDLE);
    nd = 0;
    repeat (5) begin cycle(-1); if (s_dn[0]) nd++; end
    chk("abort_no_done", 0, nd, 0);
    vld[0] = 1'b1; dat[0] = 4'b1001;
    cycle(-1);
    chk("abort_reaccept", 0, s_ld[0], 1'b1);
    vld[0] = 1'b0;
    repeat (6) cycle(-1);

    // asynchronous reset mid-shift
    vld[0] = 1'b1; dat[0] = 4'b1011;
    cycle(-1);
    vld[0] = 1'b0;
    cycle(-1);
    cycle(-1);
    #2 rst_n = 1'b0;
    model_reset_all();
    #1;
    chk("arst_ser", 0, so[0], 1'b0);
    chk("arst_busy", 0, bsy[0], 1'b0);
    chk("arst_ready", 0, rdy, 2'b00);
    chk("arst_done", 0, dn[0], 1'b0);
    cycle(-1);
    cycle(-1);
    rst_n = 1'b1;
    cycle(-1);
    run_table();

    // randomized traffic on both instances
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 2; i++) begin
        vld[i] = ($urandom_range(0, 3) != 0);
        dat[i] = W'($urandom);
        abt[i] = ($urandom_range(0, 15) == 0);
      end
      cycle(-1);
    end
    vld = 2'b00; abt = 2'b00;
    repeat (20) cycle(-1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
